// File: rtl/mem_req_ctrl_pkg.sv
// mem_req_ctrl_pkg: width helpers and request bundle shared by the memory request controller and its bench
package mem_req_ctrl_pkg;
  localparam int BIT_WIDTH_D = 128;
  localparam int WORD_DEPTH_D = 64;
  function automatic int AW_F(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
  function automatic int BE_W_F(input int width);
    return width / 8;
  endfunction
  typedef struct packed {
    logic we;
    logic [BE_W_F(BIT_WIDTH_D)-1:0] be;
    logic [AW_F(WORD_DEPTH_D)-1:0] addr;
    logic [BIT_WIDTH_D-1:0] dat;
  } mem_req_t;
endpackage

// File: rtl/mem_req_ctrl_rspq.sv
// mem_req_ctrl_rspq: synchronous FIFO with wrapping pointers, used to hold read responses
module mem_req_ctrl_rspq import mem_req_ctrl_pkg::*; #(
  parameter int W = 128,
  parameter int DEPTH = 2,
  localparam int PW = AW_F(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= din;
  assign dout = mem[rd_ptr];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: valid/ready to active-low SRAM strobe bridge with queued read responses; MEM_REQ_CTRL_BM_EN enables the byte mask
module mem_req_ctrl import mem_req_ctrl_pkg::*; #(
  parameter int BIT_WIDTH = 128,
  parameter int WORD_DEPTH = 64,
  parameter int RSP_DEPTH = 2,
  localparam int AW = AW_F(WORD_DEPTH),
  localparam int BE_W = BE_W_F(BIT_WIDTH),
  localparam int CW = $clog2(RSP_DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [BE_W-1:0]      req_be_i,
  input  logic [AW-1:0]        req_addr_i,
  input  logic [BIT_WIDTH-1:0] req_dat_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [BIT_WIDTH-1:0] rsp_dat_o,
  output logic                 mem_en_o,
  output logic                 mem_wen_o,
  output logic [BE_W-1:0]      mem_bm_o,
  output logic [AW-1:0]        mem_addr_o,
  output logic [BIT_WIDTH-1:0] mem_dat_o,
  input  logic [BIT_WIDTH-1:0] mem_dat_i
);
  logic rd_inflight, fire, pop, full, empty;
  logic [CW-1:0] count;
  logic [CW:0] need;
  logic [BE_W+AW+BIT_WIDTH:0] req_bus;
  assign pop = rsp_valid_o & rsp_ready_i;
  // a read in flight already owns a queue slot, so credit counts it before it lands
  assign need = (CW+1)'(count) + (CW+1)'(rd_inflight) - (CW+1)'(pop);
  assign req_ready_o = ~rst_i & (need < (CW+1)'(RSP_DEPTH));
  assign fire = req_valid_i & req_ready_o;
  assign mem_en_o = ~fire;
  assign mem_wen_o = ~(fire & req_we_i);
  assign mem_addr_o = req_addr_i;
  assign mem_dat_o = req_dat_i;
`ifdef MEM_REQ_CTRL_BM_EN
  assign mem_bm_o = ~req_be_i;
`else
  assign mem_bm_o = '0;
`endif
  always_ff @(posedge clk_i) rd_inflight <= rst_i ? 1'b0 : fire & ~req_we_i;
  mem_req_ctrl_rspq #(.W(BIT_WIDTH), .DEPTH(RSP_DEPTH)) u_rspq (
    .clk(clk_i),
    .rst(rst_i),
    .push(rd_inflight),
    .pop(pop),
    .din(mem_dat_i),
    .dout(rsp_dat_o),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign rsp_valid_o = ~empty;
  assign req_bus = {req_we_i, req_be_i, req_addr_i, req_dat_i};
  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(rd_inflight && full));
  a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (req_valid_i && !req_ready_o) |=> $stable(req_bus));
endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: scoreboard bench for mem_req_ctrl against a behavioural single-port macro
module tb_mem_req_ctrl;
  import mem_req_ctrl_pkg::*;
  localparam int BW = BIT_WIDTH_D;
  localparam int WD = WORD_DEPTH_D;
  localparam int AW = AW_F(WD);
  localparam int BEW = BE_W_F(BW);
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic req_valid_i = 1'b0, req_ready_o, req_we_i = 1'b0;
  logic [BEW-1:0] req_be_i = '0;
  logic [AW-1:0] req_addr_i = '0;
  logic [BW-1:0] req_dat_i = '0;
  logic rsp_valid_o, rsp_ready_i = 1'b1;
  logic [BW-1:0] rsp_dat_o, mem_dat_o, mem_dat_i;
  logic mem_en_o, mem_wen_o;
  logic [BEW-1:0] mem_bm_o;
  logic [AW-1:0] mem_addr_o;
  always #5 clk_i = ~clk_i;
  mem_req_ctrl #(.BIT_WIDTH(BW), .WORD_DEPTH(WD), .RSP_DEPTH(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_be_i(req_be_i), .req_addr_i(req_addr_i), .req_dat_i(req_dat_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
    .mem_en_o(mem_en_o), .mem_wen_o(mem_wen_o), .mem_bm_o(mem_bm_o),
    .mem_addr_o(mem_addr_o), .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i)
  );
  // behavioural macro: read data is only meaningful the cycle after a read strobe
  logic [BW-1:0] mac [WD];
  always @(posedge clk_i)
    if (!mem_en_o && !mem_wen_o)
      for (int b = 0; b < BEW; b++) if (!mem_bm_o[b]) mac[mem_addr_o][b*8 +: 8] <= mem_dat_o[b*8 +: 8];
  always @(posedge clk_i)
    mem_dat_i <= (!mem_en_o && mem_wen_o) ? mac[mem_addr_o] : {$urandom, $urandom, $urandom, $urandom};
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;
  logic [BW-1:0] ref_mem [WD];
  logic [BW-1:0] exp_q [$];
  int pop_cyc [$];
  int n_cmp = 0, n_bad = 0;
  logic hold = 1'b0;
  logic [BW-1:0] hold_dat, e;
  always @(negedge clk_i) begin
    if (!rst_i && hold) begin
      n_cmp++;
      if (rsp_valid_o !== 1'b1 || rsp_dat_o !== hold_dat) begin
        n_bad++;
        $display("FAIL rsp_stable: valid=%b dat=%h required valid=1 dat=%h", rsp_valid_o, rsp_dat_o, hold_dat);
      end
    end
    hold = !rst_i && rsp_valid_o === 1'b1 && !rsp_ready_i;
    hold_dat = rsp_dat_o;
    if (!rst_i && rsp_valid_o === 1'b1 && rsp_ready_i) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rsp_unexpected: dat=%h at cycle %0d required no response", rsp_dat_o, cyc);
      end else begin
        e = exp_q.pop_front();
        if (rsp_dat_o !== e) begin
          n_bad++;
          $display("FAIL rsp_data: got %h required %h", rsp_dat_o, e);
        end
      end
      pop_cyc.push_back(cyc);
    end
  end
  function automatic mem_req_t mk(input logic we, input logic [BEW-1:0] be, input int addr, input logic [BW-1:0] dat);
    mem_req_t r;
    r.we = we;
    r.be = be;
    r.addr = AW'(addr);
    r.dat = dat;
    return r;
  endfunction
  task automatic issue(input mem_req_t r, output int waited);
    logic [BEW-1:0] be_eff, bm_exp;
    req_valid_i = 1'b1;
    req_we_i = r.we;
    req_be_i = r.be;
    req_addr_i = r.addr;
    req_dat_i = r.dat;
    waited = 0;
    @(negedge clk_i);
    while (!req_ready_o && waited < 50) begin
      waited++;
      @(negedge clk_i);
    end
    n_cmp++;
    if (!req_ready_o) begin
      n_bad++;
      $display("FAIL req_accept_timeout: ready=%b after %0d cycles required 1", req_ready_o, waited);
    end else begin
`ifdef MEM_REQ_CTRL_BM_EN
      be_eff = r.be;
      bm_exp = ~r.be;
`else
      be_eff = '1;
      bm_exp = '0;
`endif
      n_cmp++;
      if ({mem_en_o, mem_wen_o, mem_bm_o, mem_addr_o, mem_dat_o} !== {1'b0, ~r.we, bm_exp, r.addr, r.dat}) begin
        n_bad++;
        $display("FAIL strobe: en=%b wen=%b bm=%h addr=%0d required en=0 wen=%b bm=%h addr=%0d",
                 mem_en_o, mem_wen_o, mem_bm_o, mem_addr_o, ~r.we, bm_exp, r.addr);
      end
      if (r.we) begin
        for (int b = 0; b < BEW; b++) if (be_eff[b]) ref_mem[r.addr][b*8 +: 8] = r.dat[b*8 +: 8];
      end else exp_q.push_back(ref_mem[r.addr]);
    end
    @(posedge clk_i); #1;
  endtask
  task automatic idle(input int n);
    req_valid_i = 1'b0;
    repeat (n) begin @(posedge clk_i); #1; end
  endtask
  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk_i);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d responses outstanding required 0", exp_q.size());
    end
    @(posedge clk_i); #1;
  endtask
  task automatic check_bit(input string name, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b required %b", name, got, want);
    end
  endtask
  task automatic test_reset();
    req_valid_i = 1'b1;
    req_we_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_bit("reset_req_ready", req_ready_o, 1'b0);
    check_bit("reset_rsp_valid", rsp_valid_o, 1'b0);
    check_bit("reset_mem_en", mem_en_o, 1'b1);
    check_bit("reset_mem_wen", mem_wen_o, 1'b1);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
  endtask
  task automatic test_write_read();
    int w;
    issue(mk(1'b1, '1, 5, {4{32'hDEAD_BEEF}}), w);
    idle(3);
    @(negedge clk_i);
    check_bit("write_no_rsp", rsp_valid_o, 1'b0);
    @(posedge clk_i); #1;
    issue(mk(1'b0, '0, 5, '0), w);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    check_bit("read_lat1_no_valid", rsp_valid_o, 1'b0);
    @(negedge clk_i);
    check_bit("read_lat2_valid", rsp_valid_o, 1'b1);
    drain();
  endtask
  task automatic test_back_to_back();
    int w, fc;
    for (int i = 0; i < 8; i++) issue(mk(1'b1, '1, i, {4{32'h1000_0000 + 32'(i)}}), w);
    pop_cyc.delete();
    fc = cyc;
    for (int i = 0; i < 8; i++) begin
      issue(mk(1'b0, '0, i, '0), w);
      n_cmp++;
      if (w != 0) begin
        n_bad++;
        $display("FAIL b2b_ready: read %0d waited %0d cycles required 0", i, w);
      end
    end
    idle(0);
    drain();
    n_cmp++;
    if (pop_cyc.size() != 8) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d responses required 8", pop_cyc.size());
    end else for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (pop_cyc[i] != fc + 2 + i) begin
        n_bad++;
        $display("FAIL b2b_timing: response %0d at cycle %0d required %0d", i, pop_cyc[i], fc + 2 + i);
      end
    end
  endtask
  task automatic offer_reads(input int cycles, inout int acc);
    for (int i = 0; i < cycles && acc < 4; i++) begin
      @(negedge clk_i);
      if (req_ready_o) begin
        exp_q.push_back(ref_mem[acc]);
        acc++;
      end
      @(posedge clk_i); #1;
      if (acc < 4) req_addr_i = AW'(acc);
      else req_valid_i = 1'b0;
    end
  endtask
  task automatic test_backpressure();
    int acc = 0;
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1;
    req_we_i = 1'b0;
    req_addr_i = '0;
    offer_reads(6, acc);
    n_cmp++;
    if (acc != 2) begin
      n_bad++;
      $display("FAIL bp_accepted: got %0d required 2", acc);
    end
    @(negedge clk_i);
    check_bit("bp_ready_low", req_ready_o, 1'b0);
    check_bit("bp_rsp_valid", rsp_valid_o, 1'b1);
    n_cmp++;
    if (rsp_dat_o !== ref_mem[0]) begin
      n_bad++;
      $display("FAIL bp_rsp_dat: got %h required %h", rsp_dat_o, ref_mem[0]);
    end
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b1;
    offer_reads(20, acc);
    n_cmp++;
    if (acc != 4) begin
      n_bad++;
      $display("FAIL bp_resume: accepted %0d required 4", acc);
    end
    idle(0);
    drain();
  endtask
  task automatic test_byte_mask();
    int w;
    logic [BW-1:0] pat;
    for (int b = 0; b < BEW; b++) pat[b*8 +: 8] = 8'(b * 17);
    issue(mk(1'b1, '1, 9, pat), w);
    issue(mk(1'b1, 16'h0001, 9, {16{8'hAA}}), w);
    issue(mk(1'b0, '0, 9, '0), w);
    idle(0);
    drain();
  endtask
  task automatic test_reset_mid();
    int w;
    issue(mk(1'b1, '1, 3, {4{32'h0BAD_F00D}}), w);
    issue(mk(1'b0, '0, 3, '0), w);
    rst_i = 1'b1;
    exp_q.delete();
    @(negedge clk_i);
    check_bit("midrst_mem_en", mem_en_o, 1'b1);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check_bit("midrst_rsp_valid", rsp_valid_o, 1'b0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    issue(mk(1'b0, '0, 3, '0), w);
    n_cmp++;
    if (w != 0) begin
      n_bad++;
      $display("FAIL midrst_resume: waited %0d cycles required 0", w);
    end
    req_valid_i = 1'b0;
    @(negedge clk_i);
    check_bit("midrst_no_stale", rsp_valid_o, 1'b0);
    drain();
    idle(4);
  endtask
  task automatic test_wr_rd_same();
    int w;
    issue(mk(1'b1, '1, 12, {4{32'hC0DE_0012}}), w);
    issue(mk(1'b0, '0, 12, '0), w);
    idle(0);
    drain();
  endtask
  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_byte_mask();
    test_reset_mid();
    test_wr_rd_same();
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
